fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_pkg.sv | 15 +
 rtl/fwd_hazard_if.sv | 28 ++
 rtl/fwd_match.sv | 25 ++
 rtl/fwd_hazard_unit.sv | 112 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_pkg.sv
// fwd_hazard_pkg: shared slot tag, stall FSM state and forward-select encoding for fwd_hazard_unit
package fwd_hazard_pkg;
  localparam int ADDR_MAX_W = 8;
  localparam int FWD_RF = 0;
  typedef struct packed {
    logic valid;
    logic [ADDR_MAX_W-1:0] dst;
    logic wr;
    logic ld;
  } slot_t;
  typedef enum logic {RUN, LDSTALL} state_t;
  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fwd_hazard_if.sv
// fwd_hazard_if: ID-stage request and forward/stall response bundle of fwd_hazard_unit
interface fwd_hazard_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH = 2
);
  localparam int FWD_SEL_W = fwd_hazard_pkg::sel_w(FWD_DEPTH);
  logic id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
  logic [NUM_SRC-1:0] id_src_used;
  logic [REG_ADDR_W-1:0] id_dst;
  logic id_reg_write;
  logic id_mem_read;
  logic flush;
  logic stall;
  logic [NUM_SRC*FWD_SEL_W-1:0] fwd_sel;
  logic fwd_active;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_fwd_cnt;
  modport master (
    output id_valid, id_src, id_src_used, id_dst, id_reg_write, id_mem_read, flush,
    input stall, fwd_sel, fwd_active, perf_stall_cnt, perf_fwd_cnt
  );
  modport slave (
    input id_valid, id_src, id_src_used, id_dst, id_reg_write, id_mem_read, flush,
    output stall, fwd_sel, fwd_active, perf_stall_cnt, perf_fwd_cnt
  );
endinterface

// File: rtl/fwd_match.sv
// fwd_match: youngest-first search of tracked slots FIRST..FWD_DEPTH for a writer of one source register
module fwd_match
  import fwd_hazard_pkg::*;
#(
  parameter int FWD_DEPTH = 2,
  parameter int FIRST = 1,
  parameter int SEL_W = sel_w(FWD_DEPTH)
)(
  input logic [FWD_DEPTH:FIRST] wr,
  input logic [FWD_DEPTH:FIRST][ADDR_MAX_W-1:0] dst,
  input logic [ADDR_MAX_W-1:0] src,
  input logic used,
  output logic hit,
  output logic [SEL_W-1:0] idx
);
  always_comb begin
    hit = 1'b0;
    idx = SEL_W'(FWD_RF);
    for (int k = FWD_DEPTH; k >= FIRST; k--)
      if (used && src != '0 && wr[k] && dst[k] == src) begin
        hit = 1'b1;
        idx = SEL_W'(k);
      end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding select and load-use stall FSM; define HAZ_PERF_EN for saturating perf counters
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT = 1
)(
  input logic clk,
  input logic rst_n,
  fwd_hazard_if.slave bus
);
  localparam int FWD_SEL_W = sel_w(FWD_DEPTH);
  localparam int CNT_W = 3;
  slot_t [FWD_DEPTH:0] slot_q, slot_d;
  slot_t new_slot;
  logic [FWD_DEPTH:0] slot_wr;
  logic [FWD_DEPTH:0][ADDR_MAX_W-1:0] slot_dst;
  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src_q, ex_src_d;
  logic [NUM_SRC-1:0] ex_used_q, ex_used_d, fwd_hit, haz_hit;
  logic [NUM_SRC-1:0][FWD_SEL_W-1:0] fwd_idx, haz_idx;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, need;
  logic hazard, stall, take, fwd_active;

  for (genvar k = 0; k <= FWD_DEPTH; k++) begin : g_slot
    assign slot_wr[k] = slot_q[k].valid && slot_q[k].wr;
    assign slot_dst[k] = slot_q[k].dst;
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(.FWD_DEPTH(FWD_DEPTH), .FIRST(1), .SEL_W(FWD_SEL_W)) u_fwd (
      .wr(slot_wr[FWD_DEPTH:1]),
      .dst(slot_dst[FWD_DEPTH:1]),
      .src(ADDR_MAX_W'(ex_src_q[i*REG_ADDR_W +: REG_ADDR_W])),
      .used(ex_used_q[i]),
      .hit(fwd_hit[i]),
      .idx(fwd_idx[i])
    );
    fwd_match #(.FWD_DEPTH(FWD_DEPTH), .FIRST(0), .SEL_W(FWD_SEL_W)) u_haz (
      .wr(slot_wr),
      .dst(slot_dst),
      .src(ADDR_MAX_W'(bus.id_src[i*REG_ADDR_W +: REG_ADDR_W])),
      .used(bus.id_src_used[i]),
      .hit(haz_hit[i]),
      .idx(haz_idx[i])
    );
  end

  always_comb begin
    hazard = 1'b0;
    need = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (haz_hit[i] && slot_q[haz_idx[i]].ld && haz_idx[i] < FWD_SEL_W'(LOAD_LAT)) begin
        hazard = 1'b1;
        need = CNT_W'(LOAD_LAT) - CNT_W'(haz_idx[i]) > need ? CNT_W'(LOAD_LAT) - CNT_W'(haz_idx[i]) : need;
      end
  end

  assign fwd_active = |fwd_hit;
  assign stall = !bus.flush && (state_q == LDSTALL || (hazard && bus.id_valid));
  assign bus.stall = stall;
  assign bus.fwd_sel = fwd_idx;
  assign bus.fwd_active = fwd_active;

  always_comb begin
    take = !stall && !bus.flush;
    new_slot = take ? {bus.id_valid, ADDR_MAX_W'(bus.id_dst), bus.id_reg_write, bus.id_mem_read} : '0;
    slot_d = {slot_q[FWD_DEPTH-1:0], new_slot};
    ex_src_d = take ? bus.id_src : '0;
    ex_used_d = take ? bus.id_src_used : '0;
    cnt_d = bus.flush ? '0 : state_q == LDSTALL ? cnt_q - CNT_W'(1) : stall ? need - CNT_W'(1) : '0;
    state_d = cnt_d != '0 ? LDSTALL : RUN;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot_q <= '0;
      ex_src_q <= '0;
      ex_used_q <= '0;
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      slot_q <= slot_d;
      ex_src_q <= ex_src_d;
      ex_used_q <= ex_used_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
    end

`ifdef HAZ_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_fwd_q, perf_fwd_d;
  always_comb begin
    perf_stall_d = stall && !(&perf_stall_q) ? perf_stall_q + 32'd1 : perf_stall_q;
    perf_fwd_d = fwd_active && !(&perf_fwd_q) ? perf_fwd_q + 32'd1 : perf_fwd_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_fwd_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_fwd_q <= perf_fwd_d;
    end
  assign bus.perf_stall_cnt = perf_stall_q;
  assign bus.perf_fwd_cnt = perf_fwd_q;
`else
  assign bus.perf_stall_cnt = '0;
  assign bus.perf_fwd_cnt = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: table-driven checks of fwd_hazard_unit at default params and at LOAD_LAT=2/FWD_DEPTH=3
module tb_fwd_hazard_unit;
  typedef struct {
    logic v;
    logic [4:0] s0, s1;
    logic [1:0] u;
    logic [4:0] d;
    logic w, l, f;
    logic st;
    logic [3:0] sel;
    logic ac;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  vec_t t0[20];
  vec_t t1[16];

  always #5 clk = ~clk;

  fwd_hazard_if #(.NUM_SRC(2), .REG_ADDR_W(5), .FWD_DEPTH(2)) b0();
  fwd_hazard_if #(.NUM_SRC(2), .REG_ADDR_W(5), .FWD_DEPTH(3)) b1();

  fwd_hazard_unit #(.NUM_SRC(2), .REG_ADDR_W(5), .FWD_DEPTH(2), .LOAD_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  fwd_hazard_unit #(.NUM_SRC(2), .REG_ADDR_W(5), .FWD_DEPTH(3), .LOAD_LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  function automatic vec_t mk(input int v, s0, s1, u, d, w, l, f, st, sel, ac);
    mk = '{v[0], s0[4:0], s1[4:0], u[1:0], d[4:0], w[0], l[0], f[0], st[0], sel[3:0], ac[0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else passed++;
  endtask

  task automatic drive(input vec_t r);
    b0.id_valid = r.v;
    b0.id_src = {r.s1, r.s0};
    b0.id_src_used = r.u;
    b0.id_dst = r.d;
    b0.id_reg_write = r.w;
    b0.id_mem_read = r.l;
    b0.flush = r.f;
    b1.id_valid = r.v;
    b1.id_src = {r.s1, r.s0};
    b1.id_src_used = r.u;
    b1.id_dst = r.d;
    b1.id_reg_write = r.w;
    b1.id_mem_read = r.l;
    b1.flush = r.f;
  endtask

  task automatic run_row(input vec_t r, input bit on1, input int n);
    drive(r);
    @(negedge clk);
    chk($sformatf("t%0d[%0d].stall", on1, n), on1 ? b1.stall : b0.stall, r.st);
    chk($sformatf("t%0d[%0d].fwd_sel", on1, n), on1 ? b1.fwd_sel : b0.fwd_sel, r.sel);
    chk($sformatf("t%0d[%0d].fwd_active", on1, n), on1 ? b1.fwd_active : b0.fwd_active, r.ac);
    @(posedge clk);
    #1;
  endtask

  initial begin
    t0[0]  = mk(1, 1, 2, 3, 3, 1, 0, 0, 0, 0, 0);
    t0[1]  = mk(1, 3, 1, 3, 5, 1, 0, 0, 0, 0, 0);
    t0[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    t0[3]  = mk(1, 1, 2, 3, 3, 1, 0, 0, 0, 0, 0);
    t0[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    t0[5]  = mk(1, 2, 3, 3, 6, 1, 0, 0, 0, 0, 0);
    t0[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 1);
    t0[7]  = mk(1, 1, 0, 1, 4, 1, 1, 0, 0, 0, 0);
    t0[8]  = mk(1, 4, 4, 3, 5, 1, 0, 0, 1, 0, 0);
    t0[9]  = mk(1, 4, 4, 3, 5, 1, 0, 0, 0, 0, 0);
    t0[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 1);
    t0[11] = mk(1, 1, 2, 3, 0, 1, 0, 0, 0, 0, 0);
    t0[12] = mk(1, 0, 0, 3, 7, 1, 0, 0, 0, 0, 0);
    t0[13] = mk(1, 1, 2, 3, 3, 1, 0, 0, 0, 0, 0);
    t0[14] = mk(1, 1, 2, 3, 3, 1, 0, 0, 0, 0, 0);
    t0[15] = mk(1, 3, 3, 3, 8, 1, 0, 0, 0, 0, 0);
    t0[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1);
    t0[17] = mk(1, 1, 0, 1, 4, 1, 1, 0, 0, 0, 0);
    t0[18] = mk(1, 4, 4, 3, 5, 1, 0, 1, 0, 0, 0);
    t0[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    t1[0]  = mk(1, 1, 0, 1, 4, 1, 1, 0, 0, 0, 0);
    t1[1]  = mk(1, 4, 4, 3, 5, 1, 0, 0, 1, 0, 0);
    t1[2]  = mk(1, 4, 4, 3, 5, 1, 0, 0, 1, 0, 0);
    t1[3]  = mk(1, 4, 4, 3, 5, 1, 0, 0, 0, 0, 0);
    t1[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 1);
    t1[5]  = mk(1, 1, 0, 1, 9, 1, 1, 0, 0, 0, 0);
    t1[6]  = mk(1, 1, 0, 1, 9, 1, 0, 0, 0, 0, 0);
    t1[7]  = mk(1, 9, 0, 1, 10, 1, 0, 0, 0, 0, 0);
    t1[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    t1[9]  = mk(1, 1, 0, 1, 4, 1, 1, 0, 0, 0, 0);
    t1[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    t1[11] = mk(1, 4, 0, 1, 11, 1, 0, 0, 1, 0, 0);
    t1[12] = mk(1, 4, 0, 1, 11, 1, 0, 0, 0, 0, 0);
    t1[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
    t1[14] = mk(1, 1, 0, 1, 4, 1, 1, 0, 0, 0, 0);
    t1[15] = mk(1, 4, 0, 1, 11, 1, 0, 0, 1, 0, 0);
    drive(mk(1, 4, 4, 3, 5, 1, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("rst.stall0", b0.stall, 0);
    chk("rst.fwd_sel0", b0.fwd_sel, 0);
    chk("rst.fwd_active0", b0.fwd_active, 0);
    chk("rst.perf_stall0", b0.perf_stall_cnt, 0);
    chk("rst.perf_fwd0", b0.perf_fwd_cnt, 0);
    chk("rst.stall1", b1.stall, 0);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) run_row(t0[n], 1'b0, n);
`ifdef HAZ_PERF_EN
    chk("perf_stall", b0.perf_stall_cnt, 1);
    chk("perf_fwd", b0.perf_fwd_cnt, 4);
`else
    chk("perf_stall", b0.perf_stall_cnt, 0);
    chk("perf_fwd", b0.perf_fwd_cnt, 0);
`endif
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("perf_stall_rst", b0.perf_stall_cnt, 0);
    chk("perf_fwd_rst", b0.perf_fwd_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 16; n++) run_row(t1[n], 1'b1, n);
    chk("mid.stall_before", b1.stall, 1);
    rst_n = 1'b0;
    #1;
    chk("mid.stall_rst", b1.stall, 0);
    chk("mid.fwd_sel_rst", b1.fwd_sel, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid.stall_after", b1.stall, 0);
    @(posedge clk);
    #1;
    chk("mid.stall_after2", b1.stall, 0);
    chk("mid.fwd_sel_after", b1.fwd_sel, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
